// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl shared definitions: states, control encodings, instruction classing.
// Decode helper maps IR fields to datapath controls and legality.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        STATE_FETCH  = 3'd0,
        STATE_DECODE = 3'd1,
        STATE_EXEC   = 3'd2,
        STATE_MEM    = 3'd3,
        STATE_WB     = 3'd4,
        STATE_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
    localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
    localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
    localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
    localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

    localparam logic [4:0] ALUOp_nop   = 5'd0;
    localparam logic [4:0] ALUOp_lui   = 5'd1;
    localparam logic [4:0] ALUOp_auipc = 5'd2;
    localparam logic [4:0] ALUOp_add   = 5'd3;
    localparam logic [4:0] ALUOp_sub   = 5'd4;
    localparam logic [4:0] ALUOp_sll   = 5'd5;
    localparam logic [4:0] ALUOp_slt   = 5'd6;
    localparam logic [4:0] ALUOp_sltu  = 5'd7;
    localparam logic [4:0] ALUOp_xor   = 5'd8;
    localparam logic [4:0] ALUOp_srl   = 5'd9;
    localparam logic [4:0] ALUOp_sra   = 5'd10;
    localparam logic [4:0] ALUOp_or    = 5'd11;
    localparam logic [4:0] ALUOp_and   = 5'd12;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WDSel_FromALU = 2'b00;
    localparam logic [1:0] WDSel_FromMEM = 2'b01;
    localparam logic [1:0] WDSel_FromPC  = 2'b10;

    localparam logic [2:0] dm_byte              = 3'b001;
    localparam logic [2:0] dm_halfword          = 3'b010;
    localparam logic [2:0] dm_word              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;
    localparam logic [2:0] dm_halfword_unsigned = 3'b101;

    localparam logic [2:0] st_byte     = dm_byte;
    localparam logic [2:0] st_halfword = dm_halfword;
    localparam logic [2:0] st_word     = dm_word;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BR, CLS_JAL, CLS_JALR
    } cls_e;

    typedef struct packed {
        logic       illegal;
        cls_e       cls;
        logic [5:0] ext;
        logic [4:0] alu;
        logic       src;
        logic [1:0] wd;
        logic [2:0] dm;
    } dec_t;

    function automatic logic [4:0] alu_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [4:0] a;
        a = ALUOp_nop;
        unique case (f3)
            3'b000: a = alt ? ALUOp_sub : ALUOp_add;
            3'b001: a = ALUOp_sll;
            3'b010: a = ALUOp_slt;
            3'b011: a = ALUOp_sltu;
            3'b100: a = ALUOp_xor;
            3'b101: a = alt ? ALUOp_sra : ALUOp_srl;
            3'b110: a = ALUOp_or;
            default: a = ALUOp_and;
        endcase
        return a;
    endfunction

    function automatic dec_t decode(
        input logic [6:0] op,
        input logic [6:0] f7,
        input logic [2:0] f3
    );
        dec_t d;
        logic f7_z;
        logic f7_a;
        f7_z = (f7 == 7'b0000000);
        f7_a = (f7 == 7'b0100000);
        d = '0;
        unique case (1'b1)
            (op == OP_R): begin
                d.illegal = !(f7_z || (f7_a && (f3 == 3'b000 || f3 == 3'b101)));
                d.alu = alu_f3(f3, f7_a);
            end
            (op == OP_IMM): begin
                d.ext = (f3 == 3'b001 || f3 == 3'b101) ?
                        EXT_CTRL_ITYPE_SHAMT : EXT_CTRL_ITYPE;
                d.alu = alu_f3(f3, f3 == 3'b101 && f7_a);
                d.src = 1'b1;
                if (f3 == 3'b001)
                    d.illegal = !f7_z;
                else if (f3 == 3'b101)
                    d.illegal = !(f7_z || f7_a);
            end
            (op == OP_LOAD): begin
                d.cls = CLS_LOAD;
                d.ext = EXT_CTRL_ITYPE;
                d.alu = ALUOp_add;
                d.src = 1'b1;
                d.wd  = WDSel_FromMEM;
                unique case (f3)
                    3'b000: d.dm = dm_byte;
                    3'b001: d.dm = dm_halfword;
                    3'b010: d.dm = dm_word;
                    3'b100: d.dm = dm_byte_unsigned;
                    3'b101: d.dm = dm_halfword_unsigned;
                    default: d.illegal = 1'b1;
                endcase
            end
            (op == OP_STORE): begin
                d.cls = CLS_STORE;
                d.ext = EXT_CTRL_STYPE;
                d.alu = ALUOp_add;
                d.src = 1'b1;
                unique case (f3)
                    3'b000: d.dm = st_byte;
                    3'b001: d.dm = st_halfword;
                    3'b010: d.dm = st_word;
                    default: d.illegal = 1'b1;
                endcase
            end
            (op == OP_BR): begin
                d.cls = CLS_BR;
                d.ext = EXT_CTRL_BTYPE;
                d.alu = ALUOp_sub;
                d.illegal = (f3 == 3'b010 || f3 == 3'b011);
            end
            (op == OP_JAL): begin
                d.cls = CLS_JAL;
                d.ext = EXT_CTRL_JTYPE;
                d.alu = ALUOp_add;
                d.src = 1'b1;
                d.wd  = WDSel_FromPC;
            end
            (op == OP_JALR): begin
                d.cls = CLS_JALR;
                d.ext = EXT_CTRL_ITYPE;
                d.alu = ALUOp_add;
                d.src = 1'b1;
                d.wd  = WDSel_FromPC;
            end
            (op == OP_LUI): begin
                d.ext = EXT_CTRL_UTYPE;
                d.alu = ALUOp_lui;
                d.src = 1'b1;
            end
            (op == OP_AUIPC): begin
                d.ext = EXT_CTRL_UTYPE;
                d.alu = ALUOp_auipc;
                d.src = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle for mc_ctrl.
// master is the controller side, slave the datapath side.
interface mc_ctrl_if;
    logic [6:0] Op;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic       Zero;
    logic       Lt;
    logic       Ltu;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       dmem_req;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic [5:0] EXTOp;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic       ALUSrc;
    logic [2:0] DMType;
    logic [1:0] WDSel;
    logic       trap;
    logic       bus_err;
    logic [2:0] state;

    modport master (
        input  Op, Funct7, Funct3, Zero, Lt, Ltu, imem_ack, dmem_ack,
        output imem_req, dmem_req, IRWrite, PCWrite, RegWrite,
        output MemWrite, MemRead, EXTOp, ALUOp, NPCOp, ALUSrc,
        output DMType, WDSel, trap, bus_err, state
    );

    modport slave (
        output Op, Funct7, Funct3, Zero, Lt, Ltu, imem_ack, dmem_ack,
        input  imem_req, dmem_req, IRWrite, PCWrite, RegWrite,
        input  MemWrite, MemRead, EXTOp, ALUOp, NPCOp, ALUSrc,
        input  DMType, WDSel, trap, bus_err, state
    );
endinterface

// File: rtl/mc_ctrl_br_cond.sv
// Branch condition evaluation from Funct3 and ALU flags.
// Reserved Funct3 codes never report taken.
module mc_ctrl_br_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        unique case (funct3)
            3'b000: taken = zero;
            3'b001: taken = !zero;
            3'b100: taken = lt;
            3'b101: taken = !lt;
            3'b110: taken = ltu;
            3'b111: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB plus TRAP,
// with variable-latency memory handshakes and an optional wait timeout.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int TW           = 5
) (
    input logic      clk,
    input logic      rst,
    mc_ctrl_if.master bus
);
    localparam bit            TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

    state_e        st;
    logic          imem_req_q;
    logic          dmem_req_q;
    logic          bus_err_q;
    logic [TW-1:0] cnt;
    dec_t          dec;
    logic          taken;
    logic          to_hit;
    logic          dp_en;
    logic          pc_we;
    logic [2:0]    npc;

    assign dec = decode(bus.Op, bus.Funct7, bus.Funct3);

    mc_ctrl_br_cond u_br_cond (
        .funct3 (bus.Funct3),
        .zero   (bus.Zero),
        .lt     (bus.Lt),
        .ltu    (bus.Ltu),
        .taken  (taken)
    );

    // Counter only runs while a request waits; the last allowed wait cycle traps.
    assign to_hit = TO_EN && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= STATE_FETCH;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt        <= '0;
        end else begin
            cnt <= '0;
            unique case (st)
                STATE_FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (bus.imem_ack) begin
                        imem_req_q <= 1'b0;
                        st         <= STATE_DECODE;
                    end else if (to_hit) begin
                        imem_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                        st         <= STATE_TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STATE_DECODE: begin
                    if (!dec.illegal) begin
                        st <= STATE_EXEC;
                    end else if (ILLEGAL_TRAP) begin
                        st <= STATE_TRAP;
                    end else begin
                        st         <= STATE_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                STATE_EXEC: begin
                    if (dec.cls == CLS_LOAD || dec.cls == CLS_STORE) begin
                        st         <= STATE_MEM;
                        dmem_req_q <= 1'b1;
                    end else if (dec.cls == CLS_BR) begin
                        st         <= STATE_FETCH;
                        imem_req_q <= 1'b1;
                    end else begin
                        st <= STATE_WB;
                    end
                end
                STATE_MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        if (dec.cls == CLS_STORE) begin
                            st         <= STATE_FETCH;
                            imem_req_q <= 1'b1;
                        end else begin
                            st <= STATE_WB;
                        end
                    end else if (to_hit) begin
                        dmem_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                        st         <= STATE_TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STATE_WB: begin
                    st         <= STATE_FETCH;
                    imem_req_q <= 1'b1;
                end
                STATE_TRAP: st <= STATE_TRAP;
                default:    st <= STATE_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_we = 1'b0;
        npc   = NPC_PLUS4;
        unique case (1'b1)
            (st == STATE_DECODE): pc_we = dec.illegal && !ILLEGAL_TRAP;
            (st == STATE_EXEC): begin
                if (dec.cls == CLS_BR) begin
                    pc_we = 1'b1;
                    npc   = taken ? NPC_BRANCH : NPC_PLUS4;
                end
            end
            (st == STATE_MEM): pc_we = bus.dmem_ack && (dec.cls == CLS_STORE);
            (st == STATE_WB): begin
                pc_we = 1'b1;
                if (dec.cls == CLS_JAL)
                    npc = NPC_JUMP;
                else if (dec.cls == CLS_JALR)
                    npc = NPC_JALR;
            end
            default: pc_we = 1'b0;
        endcase
    end

    assign dp_en = (st == STATE_EXEC) || (st == STATE_MEM) || (st == STATE_WB);

    assign bus.imem_req = imem_req_q;
    assign bus.dmem_req = dmem_req_q;
    assign bus.IRWrite  = imem_req_q && bus.imem_ack;
    assign bus.PCWrite  = pc_we;
    assign bus.NPCOp    = npc;
    assign bus.RegWrite = (st == STATE_WB);
    assign bus.MemRead  = dmem_req_q && (dec.cls == CLS_LOAD);
    assign bus.MemWrite = dmem_req_q && (dec.cls == CLS_STORE);
    assign bus.EXTOp    = dp_en ? dec.ext : '0;
    assign bus.ALUOp    = dp_en ? dec.alu : '0;
    assign bus.ALUSrc   = dp_en && dec.src;
    assign bus.WDSel    = dp_en ? dec.wd : '0;
    assign bus.DMType   = dp_en ? dec.dm : '0;
    assign bus.trap     = (st == STATE_TRAP);
    assign bus.bus_err  = bus_err_q;
    assign bus.state    = st;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: two instances differing in illegal handling,
// driven by shared stimulus with hand-computed expectations.
module tb_mc_ctrl;
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] IM  = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    // {f3, zero, lt, ltu, expected NPC_BRANCH}
    localparam logic [6:0] BR_TAB [9] = '{
        {3'b000, 1'b1, 1'b0, 1'b0, 1'b1},
        {3'b000, 1'b0, 1'b1, 1'b1, 1'b0},
        {3'b001, 1'b0, 1'b0, 1'b0, 1'b1},
        {3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
        {3'b101, 1'b0, 1'b0, 1'b1, 1'b1},
        {3'b101, 1'b1, 1'b1, 1'b0, 1'b0},
        {3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
        {3'b111, 1'b0, 1'b0, 1'b1, 1'b0},
        {3'b111, 1'b1, 1'b1, 1'b0, 1'b1}
    };

    // {op, f7, f3, expected illegal}
    localparam logic [17:0] ILL_TAB [14] = '{
        {R,     7'b0100000, 3'b000, 1'b0},
        {R,     7'b0100000, 3'b001, 1'b1},
        {R,     7'b0000001, 3'b000, 1'b1},
        {IM,    7'b0100000, 3'b001, 1'b1},
        {IM,    7'b0100000, 3'b101, 1'b0},
        {IM,    7'b0000001, 3'b101, 1'b1},
        {LD,    7'b0000000, 3'b011, 1'b1},
        {LD,    7'b0000000, 3'b100, 1'b0},
        {ST,    7'b0000000, 3'b011, 1'b1},
        {ST,    7'b0000000, 3'b010, 1'b0},
        {BR,    7'b0000000, 3'b010, 1'b1},
        {BR,    7'b0000000, 3'b111, 1'b0},
        {7'h7f, 7'b0000000, 3'b000, 1'b1},
        {JAL,   7'b0000000, 3'b000, 1'b0}
    };

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       iack;
    logic       dack;
    int         n_chk;
    int         n_err;
    logic [31:0] ins;

    mc_ctrl_if bus_a ();
    mc_ctrl_if bus_b ();

    assign bus_a.Op = op;
    assign bus_a.Funct7 = f7;
    assign bus_a.Funct3 = f3;
    assign bus_a.Zero = zero;
    assign bus_a.Lt = lt;
    assign bus_a.Ltu = ltu;
    assign bus_a.imem_ack = iack;
    assign bus_a.dmem_ack = dack;
    assign bus_b.Op = op;
    assign bus_b.Funct7 = f7;
    assign bus_b.Funct3 = f3;
    assign bus_b.Zero = zero;
    assign bus_b.Lt = lt;
    assign bus_b.Ltu = ltu;
    assign bus_b.imem_ack = iack;
    assign bus_b.dmem_ack = dack;

    mc_ctrl #(.ILLEGAL_TRAP(1'b1), .MEM_TIMEOUT(4), .TW(5)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mc_ctrl #(.ILLEGAL_TRAP(1'b0), .MEM_TIMEOUT(4), .TW(5)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    wire [6:0] en_a = {bus_a.imem_req, bus_a.dmem_req, bus_a.IRWrite,
                       bus_a.PCWrite, bus_a.RegWrite, bus_a.MemWrite,
                       bus_a.MemRead};
    wire [31:0] outs_a = {en_a, bus_a.EXTOp, bus_a.ALUOp, bus_a.NPCOp,
                          bus_a.ALUSrc, bus_a.DMType, bus_a.WDSel,
                          bus_a.trap, bus_a.bus_err, bus_a.state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in a FETCH cycle with imem_req high and imem_ack high.
    task automatic fetch_dec(input logic [6:0] o, input logic [6:0] s7,
                             input logic [2:0] s3);
        chk("fetch_irw", {31'd0, bus_a.IRWrite}, 32'd1);
        tick();
        op = o;
        f7 = s7;
        f3 = s3;
        #1;
        chk("dec_state", {29'd0, bus_a.state}, {29'd0, S_DECODE});
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        op = '0;
        f7 = '0;
        f3 = '0;
        {zero, lt, ltu} = 3'b000;
        iack = 1'b1;
        dack = 1'b1;
        tick();
        tick();
        chk("rst_outs", outs_a, 32'd0);

        rst = 1'b0;
        #1;
        chk("c0_req", {31'd0, bus_a.imem_req}, 32'd0);
        tick();
        chk("c1_req", {31'd0, bus_a.imem_req}, 32'd1);
        chk("c1_irw", {31'd0, bus_a.IRWrite}, 32'd1);
        tick();
        ins = 32'h00500093;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        #1;
        chk("addi_dec", {bus_a.state, bus_a.ALUOp, bus_a.IRWrite},
            {22'd0, S_DECODE, 5'd0, 1'b0});
        tick();
        chk("addi_exec", {bus_a.state, bus_a.EXTOp, bus_a.ALUOp,
                          bus_a.ALUSrc, bus_a.RegWrite, bus_a.PCWrite},
            {17'd0, S_EXEC, 6'b010000, 5'd3, 1'b1, 1'b0, 1'b0});
        tick();
        chk("addi_wb", {bus_a.state, bus_a.RegWrite, bus_a.PCWrite,
                        bus_a.NPCOp, bus_a.WDSel},
            {22'd0, S_WB, 1'b1, 1'b1, 3'b000, 2'b00});
        tick();
        chk("addi_next", {bus_a.state, bus_a.imem_req},
            {28'd0, S_FETCH, 1'b1});

        fetch_dec(BR, 7'd0, 3'b100);
        lt = 1'b1;
        tick();
        chk("blt_t", {bus_a.PCWrite, bus_a.NPCOp, bus_a.ALUOp,
                      bus_a.RegWrite},
            {22'd0, 1'b1, 3'b001, 5'd4, 1'b0});
        tick();
        fetch_dec(BR, 7'd0, 3'b100);
        lt = 1'b0;
        tick();
        chk("blt_nt", {bus_a.PCWrite, bus_a.NPCOp, bus_a.RegWrite},
            {27'd0, 1'b1, 3'b000, 1'b0});
        tick();
        chk("blt_fetch", {bus_a.state, bus_a.RegWrite},
            {28'd0, S_FETCH, 1'b0});

        for (int i = 0; i < 9; i++) begin
            fetch_dec(BR, 7'd0, BR_TAB[i][6:4]);
            {zero, lt, ltu} = BR_TAB[i][3:1];
            tick();
            chk($sformatf("br_%0d", i), {29'd0, bus_a.NPCOp},
                {31'd0, BR_TAB[i][0]});
            tick();
        end

        dack = 1'b0;
        fetch_dec(LD, 7'd0, 3'b010);
        tick();
        chk("lw_exec", {bus_a.state, bus_a.dmem_req},
            {28'd0, S_EXEC, 1'b0});
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                dack = 1'b1;
                #1;
            end
            chk($sformatf("lw_mem%0d", i),
                {bus_a.state, bus_a.dmem_req, bus_a.MemRead, bus_a.MemWrite},
                {26'd0, S_MEM, 3'b110});
        end
        tick();
        chk("lw_wb", {bus_a.state, bus_a.RegWrite, bus_a.WDSel,
                      bus_a.DMType, bus_a.dmem_req},
            {22'd0, S_WB, 1'b1, 2'b01, 3'b011, 1'b0});
        tick();

        fetch_dec(ST, 7'd0, 3'b000);
        tick();
        tick();
        chk("sb_mem", {bus_a.MemWrite, bus_a.MemRead, bus_a.DMType,
                       bus_a.PCWrite, bus_a.NPCOp, bus_a.EXTOp},
            {18'd0, 1'b1, 1'b0, 3'b001, 1'b1, 3'b000, 6'b001000});
        tick();
        chk("sb_next", {bus_a.state, bus_a.RegWrite, bus_a.MemWrite},
            {27'd0, S_FETCH, 2'b00});

        fetch_dec(7'h7f, 7'd0, 3'b000);
        chk("ill_a_pcw", {31'd0, bus_a.PCWrite}, 32'd0);
        chk("ill_b_nop", {bus_b.PCWrite, bus_b.NPCOp}, {28'd0, 1'b1, 3'b000});
        tick();
        chk("ill_a_trap", {bus_a.trap, bus_a.state, bus_a.bus_err},
            {27'd0, 1'b1, S_TRAP, 1'b0});
        chk("ill_b_fetch", {bus_b.state, bus_b.IRWrite},
            {28'd0, S_FETCH, 1'b1});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("trap_hold%0d", i), {bus_a.trap, en_a},
                {24'd0, 1'b1, 7'd0});
        end

        for (int i = 0; i < 14; i++) begin
            reset_dut();
            tick();
            {op, f7, f3} = ILL_TAB[i][17:1];
            #1;
            chk($sformatf("ill_b_%0d", i), {31'd0, bus_b.PCWrite},
                {31'd0, ILL_TAB[i][0]});
            tick();
            chk($sformatf("ill_a_%0d", i), {29'd0, bus_a.state},
                {29'd0, ILL_TAB[i][0] ? S_TRAP : S_EXEC});
        end

        iack = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("to_c0", {31'd0, bus_a.imem_req}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_wait%0d", i), {bus_a.imem_req, bus_a.state},
                {28'd0, 1'b1, S_FETCH});
        end
        tick();
        chk("to_trap", {bus_a.trap, bus_a.bus_err, bus_a.imem_req,
                        bus_a.state},
            {26'd0, 3'b110, S_TRAP});
        chk("to_trap_b", {bus_b.trap, bus_b.bus_err}, {30'd0, 2'b11});

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", {bus_a.imem_req, bus_a.state}, 32'd0);
        iack = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("restart_c0", {31'd0, bus_a.imem_req}, 32'd0);
        tick();
        chk("restart_c1", {bus_a.imem_req, bus_a.IRWrite}, {30'd0, 2'b11});

        fetch_dec(ST, 7'd0, 3'b010);
        dack = 1'b0;
        tick();
        tick();
        chk("sw_mem", {bus_a.dmem_req, bus_a.MemWrite, bus_a.MemRead,
                       bus_a.DMType},
            {26'd0, 3'b110, 3'b011});
        #2;
        rst = 1'b1;
        #1;
        chk("async_mem", {bus_a.dmem_req, bus_a.MemWrite}, 32'd0);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the RV32I core: a Moore FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives the datapath with the existing control encodings. It adds full branch evaluation (all six conditions), store-width typing, variable-latency memory handshakes with timeout, and illegal-instruction trapping. It sits beside the datapath in place of the single-cycle decoder, reading the latched instruction fields from the IR.

## Interface
- ILLEGAL_TRAP, 1: 1 = illegal instruction enters TRAP; 0 = treated as NOP (PC+4).
- MEM_TIMEOUT, 16: max wait cycles for imem_ack/dmem_ack; 0 disables timeout.
- TW, 5: timeout counter width; MEM_TIMEOUT < 2^TW.
- Reset is asynchronous, active-high; single clock domain.
- clk  in  1  clock, rising edge
- rst  in  1  async active-high reset
- Op / Funct7 / Funct3  in  7/7/3  IR fields, stable from DECODE onward
- Zero / Lt / Ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- imem_ack / dmem_ack  in  1 each  memory done, sampled on clock edge while req high
- imem_req / dmem_req  out  1 each  memory request, held until ack
- IRWrite / PCWrite / RegWrite / MemWrite / MemRead  out  1 each  one-cycle enables
- EXTOp  out  6  immediate type (EXT_CTRL_* codes)
- ALUOp  out  5  ALU operation (ALUOp_* codes)
- NPCOp  out  3  next-PC select (NPC_PLUS4/BRANCH/JUMP/JALR)
- ALUSrc  out  1  ALU B from immediate
- DMType  out  3  access width for loads and stores (dm_* codes)
- WDSel  out  2  writeback source (WDSel_FromALU/MEM/PC)
- trap / bus_err  out  1 each  sticky: in TRAP / TRAP caused by timeout
- state  out  3  current state, debug

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req=1; on ack, IRWrite=1 → DECODE.
- DECODE: classify; illegal → TRAP (ILLEGAL_TRAP=1) or PCWrite with NPC_PLUS4 → FETCH; else → EXEC.
- EXEC: R/I/LUI/AUIPC/JAL/JALR → WB; load/store → MEM; branch → PCWrite=1, NPCOp=BRANCH if taken else PLUS4, → FETCH.
- Branch taken: BEQ Zero, BNE !Zero, BLT Lt, BGE !Lt, BLTU Ltu, BGEU !Ltu.
- MEM: dmem_req=1, MemRead (load) or MemWrite (store) held with req; on ack, store → PCWrite with PLUS4 → FETCH; load → WB.
- WB: RegWrite=1, PCWrite=1, NPCOp = JUMP (JAL), JALR (JALR), else PLUS4 → FETCH.
- TRAP: absorbing until rst; all enables and reqs 0; trap=1.
- Illegal: unknown opcode; R-type Funct7 ∉ {0000000, 0100000}, or 0100000 with Funct3 ∉ {000, 101}; SLLI/SRLI Funct7≠0000000; SRAI Funct7≠0100000; load Funct3 ∈ {011, 110, 111}; store Funct3 > 010; branch Funct3 ∈ {010, 011}.
- EXTOp/ALUOp/ALUSrc/WDSel/DMType: combinational from Op/Funct fields, valid in EXEC, MEM and WB; 0 in FETCH, DECODE, TRAP. Stores use DMType dm_byte/dm_halfword/dm_word. Branches use ALUOp_sub.

## Timing
- During rst: all outputs 0, state=FETCH, counter 0, trap/bus_err 0. imem_req rises the first cycle after rst falls.
- ack may arrive in the same cycle req rises: that cycle completes.
- Minimum cycles per instruction with zero-wait memory: branch 3, ALU/jump 4, store 4, load 5.
- Timeout counter increments each cycle req is high and ack is low; clears on ack or state change. If it reaches MEM_TIMEOUT-1 with no ack, next state is TRAP and bus_err=1.
- Async rst mid-MEM drops dmem_req and MemWrite immediately (no clock needed).
- Enables are Moore outputs, single-cycle pulses, never asserted during the same cycle as a state leaving TRAP (impossible).

## Structure
- ctrl_encode_def.v is extended with state encodings STATE_FETCH..STATE_TRAP (3 bits) and a store-width alias for dm_* codes. Existing EXT/ALU/NPC/WDSel macros are reused unchanged.
- Sub-module br_cond: Funct3 + Zero/Lt/Ltu → taken, combinational.

## Test plan
- Reset then ADDI x1,x0,5 (0x00500093), zero-wait acks: IRWrite in cycle 1, RegWrite+PCWrite (PLUS4) in cycle 4, ALUOp_add, ALUSrc=1.
- BLT with Lt=1, then with Lt=0: PCWrite in EXEC with NPCOp=BRANCH, then PLUS4; RegWrite never asserted.
- LW with dmem_ack delayed 3 cycles: dmem_req/MemRead held 4 cycles, then WB with WDSel_FromMEM, DMType=dm_word.
- SB: MemWrite with DMType=dm_byte, PCWrite on ack, no WB.
- Opcode 0x7F with ILLEGAL_TRAP=1: trap=1 after DECODE, no enables afterwards; with ILLEGAL_TRAP=0: PC+4 and fetch continues.
- MEM_TIMEOUT=4, imem_ack held low: TRAP with bus_err=1 after 4 req cycles. Assert rst mid-wait: imem_req drops asynchronously and the FSM restarts in FETCH.
